// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lif_pkg
// Purpose  : Shared definitions for the LIF sweep scheduler and its update
//            datapath. Holds the scheduler FSM state encoding and the default
//            datapath width, firing threshold and leak shift.
// Revision : 1.0 - initial release
// ============================================================================
package lif_pkg;

  // Default membrane/current width.
  localparam int LIF_W          = 8;
  // Default firing threshold (compared against the saturated potential).
  localparam int LIF_THRESHOLD  = 200;
  // Default leak shift: leak = v >> LIF_LEAK_SHIFT.
  localparam int LIF_LEAK_SHIFT = 2;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } lif_state_e;

endpackage
`default_nettype wire

// File: rtl/lif_update.sv
`default_nettype none
// ============================================================================
// Module   : lif_update
// Purpose  : Combinational leaky-integrate-and-fire update for one neuron.
//            sum = v - (v >> LEAK_SHIFT) + cur, computed one bit wider than
//            the state, saturated to 2^W-1. Fires when the saturated sum
//            reaches THRESHOLD; a firing neuron's potential resets to zero.
// Ports    : v      in  W  current membrane potential
//            cur    in  W  input current
//            next_v out W  potential to store after this update
//            fire   out 1  neuron fires on this update
// Revision : 1.0 - initial release
// ============================================================================
module lif_update
  import lif_pkg::*;
#(
  parameter int W          = LIF_W,
  parameter int THRESHOLD  = LIF_THRESHOLD,
  parameter int LEAK_SHIFT = LIF_LEAK_SHIFT
) (
  input  logic [W-1:0] v,
  input  logic [W-1:0] cur,
  output logic [W-1:0] next_v,
  output logic         fire
);

  localparam logic [W:0] c_thr = (W+1)'(THRESHOLD);

  logic [W:0]   w_sum;
  logic [W-1:0] w_sat;

  // v - (v >> s) never goes negative, so the only overflow is past 2^W-1,
  // which the extra top bit captures.
  always_comb begin
    w_sum  = {1'b0, v} - ({1'b0, v} >> LEAK_SHIFT) + {1'b0, cur};
    w_sat  = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
    fire   = ({1'b0, w_sat} >= c_thr);
    next_v = fire ? '0 : w_sat;
  end

endmodule
`default_nettype wire

// File: rtl/lif_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lif_sweep_scheduler
// Purpose  : Time-multiplexes one lif_update datapath over N virtual neurons.
//            Each start sweeps neurons 0..N-1, one UPDATE cycle each; a firing
//            neuron pauses the sweep in EMIT until its spike event is taken
//            over the valid/ready interface. A one-cycle done pulse ends the
//            sweep.
// Ports    : clk, rst_n         clock, asynchronous active-low reset
//            start              begin a sweep (honoured only in IDLE)
//            cur_we/addr/data   input current register write port
//            busy               FSM not in IDLE (registered)
//            done               end-of-sweep pulse (registered)
//            spike_valid/ready  spike event handshake
//            spike_id           index of the firing neuron (registered)
//            peek_addr/data     combinational membrane state readout
// Revision : 1.0 - initial release
// ============================================================================
module lif_sweep_scheduler
  import lif_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int W          = LIF_W,
  parameter  int THRESHOLD  = LIF_THRESHOLD,
  parameter  int LEAK_SHIFT = LIF_LEAK_SHIFT,
  localparam int AW         = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cur_we,
  input  logic [AW-1:0] cur_addr,
  input  logic [W-1:0]  cur_data,
  output logic          busy,
  output logic          done,
  output logic          spike_valid,
  input  logic          spike_ready,
  output logic [AW-1:0] spike_id,
  input  logic [AW-1:0] peek_addr,
  output logic [W-1:0]  peek_data
);

  localparam logic [AW-1:0] c_last_idx = AW'(N - 1);

  lif_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [W-1:0]  v_q   [N];
  logic [W-1:0]  v_d   [N];
  logic [W-1:0]  cur_q [N];
  logic [W-1:0]  cur_d [N];
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          spike_valid_q, spike_valid_d;
  logic [AW-1:0] spike_id_q, spike_id_d;

  logic [W-1:0]  w_next_v;
  logic          w_fire;

  lif_update #(
    .W          (W),
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_update (
    .v      (v_q[idx_q]),
    .cur    (cur_q[idx_q]),
    .next_v (w_next_v),
    .fire   (w_fire)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    v_d        = v_q;
    cur_d      = cur_q;
    spike_id_d = spike_id_q;

    // The datapath reads cur_q, so a write landing on the neuron being
    // updated this cycle only takes effect on the next sweep.
    if (cur_we) begin
      cur_d[cur_addr] = cur_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        v_d[idx_q] = w_next_v;
        if (w_fire) begin
          spike_id_d = idx_q;
          state_d    = ST_EMIT;
        end else if (idx_q == c_last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_EMIT: begin
        if (spike_ready) begin
          if (idx_q == c_last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_UPDATE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
    spike_valid_d = (state_d == ST_EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      spike_valid_q <= 1'b0;
      spike_id_q    <= '0;
      for (int i = 0; i < N; i++) begin
        v_q[i]   <= '0;
        cur_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      spike_valid_q <= spike_valid_d;
      spike_id_q    <= spike_id_d;
      for (int i = 0; i < N; i++) begin
        v_q[i]   <= v_d[i];
        cur_q[i] <= cur_d[i];
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign spike_valid = spike_valid_q;
  assign spike_id    = spike_id_q;
  assign peek_data   = v_q[peek_addr];

endmodule
`default_nettype wire

// File: tb/tb_lif_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_sweep_scheduler
// Purpose  : Self-checking bench for lif_sweep_scheduler (N=4, W=8,
//            THRESHOLD=200, LEAK_SHIFT=2). A per-neuron array model predicts
//            each sweep's spikes, final potentials and sweep length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_sweep_scheduler;

  localparam int N    = 4;
  localparam int AW   = 2;
  localparam int W    = 8;
  localparam int THR  = 200;
  localparam int LEAK = 2;
  localparam int VMAX = 255;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [W-1:0]  cur_data;
  logic          busy;
  logic          done;
  logic          spike_valid;
  logic          spike_ready;
  logic [AW-1:0] spike_id;
  logic [AW-1:0] peek_addr;
  logic [W-1:0]  peek_data;

  int n_checks;
  int n_errors;

  // Reference state: membrane potentials and currents, plain integers.
  int mv [N];
  int mc [N];

  lif_sweep_scheduler #(
    .N          (N),
    .W          (W),
    .THRESHOLD  (THR),
    .LEAK_SHIFT (LEAK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cur_we      (cur_we),
    .cur_addr    (cur_addr),
    .cur_data    (cur_data),
    .busy        (busy),
    .done        (done),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_id    (spike_id),
    .peek_addr   (peek_addr),
    .peek_data   (peek_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      mc[i] = 0;
    end
  endtask

  task automatic check_peek_all(input string tag);
    for (int i = 0; i < N; i++) begin
      peek_addr = AW'(i);
      #1;
      chk(tag, int'(peek_data), mv[i]);
    end
  endtask

  task automatic write_cur(input int a, input int d);
    cur_we   = 1'b1;
    cur_addr = AW'(a);
    cur_data = W'(d);
    @(negedge clk);
    cur_we   = 1'b0;
    mc[a]    = d;
  endtask

  // One sweep. stall_fix < 0 picks a random 0..3 cycle stall per spike.
  // wr_cyc > 0 writes cur[wr_idx]=wr_val during that sweep cycle (only used
  // where the target neuron is being updated or already done that cycle).
  task automatic sweep(input int stall_fix, input int wr_cyc, input int wr_idx,
                       input int wr_val, input bit rnd_start);
    int exp_ids[$];
    int sum, nexp, cyc, stall_left, tot_stall, cur_id, old_vlast, want;
    bit fresh, got_done;

    old_vlast = mv[N-1];
    for (int i = 0; i < N; i++) begin
      sum = mv[i] - (mv[i] / (1 << LEAK)) + mc[i];
      if (sum > VMAX) sum = VMAX;
      if (sum >= THR) begin
        exp_ids.push_back(i);
        mv[i] = 0;
      end else begin
        mv[i] = sum;
      end
    end
    nexp = exp_ids.size();

    peek_addr = AW'(N - 1);
    start     = 1'b1;
    @(negedge clk);
    cyc = 0; tot_stall = 0; fresh = 1'b1; got_done = 1'b0;
    stall_left = 0; cur_id = 0;
    while (!got_done && cyc < 200) begin
      cyc++;
      start  = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      cur_we = 1'b0;
      if (cyc == wr_cyc) begin
        cur_we   = 1'b1;
        cur_addr = AW'(wr_idx);
        cur_data = W'(wr_val);
      end
      chk("busy_in_sweep", int'(busy), 1);
      if (done) begin
        got_done = 1'b1;
        chk("done_cycle", cyc, N + 1 + nexp + tot_stall);
      end else if (spike_valid) begin
        if (fresh) begin
          want = (exp_ids.size() > 0) ? exp_ids.pop_front() : -1;
          chk("spike_id", int'(spike_id), want);
          cur_id     = want;
          stall_left = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
          fresh      = 1'b0;
        end else begin
          chk("spike_id_hold", int'(spike_id), cur_id);
          if (cur_id != N - 1) chk("last_not_updated", int'(peek_data), old_vlast);
        end
        if (stall_left == 0) begin
          spike_ready = 1'b1;
          fresh       = 1'b1;
        end else begin
          spike_ready = 1'b0;
          stall_left--;
          tot_stall++;
        end
      end else begin
        spike_ready = 1'($urandom_range(0, 1));
      end
      if (!got_done) @(negedge clk);
    end
    chk("sweep_completed", int'(got_done), 1);
    chk("spikes_remaining", exp_ids.size(), 0);
    start       = 1'b0;
    cur_we      = 1'b0;
    spike_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse_end", int'(done), 0);
    chk("idle_after_sweep", int'(busy), 0);
    check_peek_all("peek_after_sweep");
    if (wr_cyc > 0) mc[wr_idx] = wr_val;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_data = '0;
    spike_ready = 1'b0; peek_addr = '0;
    model_clear();
    @(negedge clk); @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(spike_valid), 0);
    chk("rst_id", int'(spike_id), 0);
    check_peek_all("rst_peek");
    rst_n = 1'b1;
    @(negedge clk);

    // Integration to a spike on neuron 0 across three sweeps.
    write_cur(0, 100);
    sweep(0, 0, 0, 0, 1'b0);   // v0 = 100
    sweep(0, 0, 0, 0, 1'b0);   // v0 = 175
    sweep(0, 0, 0, 0, 1'b0);   // 232 -> spike id 0

    // Reset while neuron 2 is in UPDATE.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_valid", int'(spike_valid), 0);
    chk("midrst_id", int'(spike_id), 0);
    check_peek_all("midrst_peek");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", int'(busy), 0);

    // Saturation.
    write_cur(1, 150);
    sweep(0, 0, 0, 0, 1'b0);   // v1 = 150
    write_cur(1, 255);
    sweep(0, 0, 0, 0, 1'b0);   // 368 -> 255 -> spike id 1

    // Every neuron fires.
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; model_clear(); @(negedge clk);
    for (int i = 0; i < N; i++) write_cur(i, 250);
    sweep(0, 0, 0, 0, 1'b0);

    // Backpressure: single spike on id 2 stalled for 5 cycles.
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; model_clear(); @(negedge clk);
    write_cur(2, 250);
    write_cur(3, 40);
    sweep(0, 0, 0, 0, 1'b0);   // v3 becomes nonzero
    sweep(5, 0, 0, 0, 1'b0);   // v3 must stay put while id 2 waits

    // Write to neuron 1 during its own UPDATE cycle, with start pulses.
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; model_clear(); @(negedge clk);
    write_cur(1, 50);
    sweep(0, 2, 1, 120, 1'b1); // uses 50 -> v1 = 50
    sweep(0, 0, 0, 0, 1'b1);   // uses 120 -> v1 = 158

    // Randomized currents, stalls and stray start pulses.
    for (int it = 0; it < 15; it++) begin
      int nw;
      nw = int'($urandom_range(0, 2));
      for (int k = 0; k < nw; k++) begin
        write_cur(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
      end
      sweep(-1, 0, 0, 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lif_sweep_scheduler.md
# lif_sweep_scheduler

Time-multiplexed controller that shares one leaky-integrate-and-fire update datapath among N virtual neurons. It holds per-neuron membrane state and input current in local registers, sweeps the neurons in index order on each `start`, and emits one spike event per firing neuron over a valid/ready interface. It sits between the tile I/O (current loading, spike readout) and the LIF arithmetic, which replaces the single hard-wired neuron instance.

## Interface
- `N`, 4, number of virtual neurons; power of two, 2..16; `AW = $clog2(N)`
- `W`, 8, membrane/current width
- `THRESHOLD`, 200, fire when updated potential ≥ this value
- `LEAK_SHIFT`, 2, leak = v >> LEAK_SHIFT

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin one sweep; sampled only in IDLE
- `cur_we`  in  1  current register write strobe
- `cur_addr`  in  AW  neuron index for write
- `cur_data`  in  W  current value
- `busy`  out  1  high whenever FSM ≠ IDLE
- `done`  out  1  one-cycle pulse at sweep end
- `spike_valid`  out  1  spike event pending
- `spike_ready`  in  1  consumer accepts event
- `spike_id`  out  AW  index of firing neuron
- `peek_addr`  in  AW  state readout index
- `peek_data`  out  W  combinational membrane state at `peek_addr`

## Operation
- FSM states: IDLE, UPDATE, EMIT, DONE.
- IDLE: on `start`=1 → idx=0, UPDATE. `start` in any other state is ignored.
- UPDATE (one cycle, neuron idx): compute next; write v[idx]. If spike → latch `spike_id`=idx, EMIT. Else idx==N-1 → DONE, otherwise idx+1, UPDATE.
- EMIT: `spike_valid`=1, `spike_id` stable. On `spike_valid & spike_ready` → idx==N-1 ? DONE : (idx+1, UPDATE). Without ready, FSM holds indefinitely.
- DONE: `done`=1 for one cycle → IDLE.
- Arithmetic: sum = v − (v >> LEAK_SHIFT) + cur[idx] in W+1 bits; saturate to 2^W−1. Spike iff saturated sum ≥ THRESHOLD; stored v = spike ? 0 : saturated sum.
- Currents persist across sweeps; they are never cleared by the sweep.
- `cur_we` is accepted in any state. If it targets the neuron in UPDATE on that cycle, the update uses the old current; the new value applies from the next sweep.
- Reset (any time, including mid-sweep or in EMIT): all v and cur = 0, idx = 0, IDLE; `busy`, `done`, `spike_valid`, `spike_id` = 0. No partial event survives.

## Timing
- `start` high at edge k: UPDATE neuron i occupies cycle k+1+i, with no spikes and no stalls.
- No-spike sweep: `busy` high cycles k+1..k+N+1, `done` in cycle k+N+1. Next `start` is accepted at edge k+N+2.
- Each spike adds one EMIT cycle plus one cycle per cycle of `spike_ready` low.
- `spike_valid`, `spike_id`, `busy`, `done` are registered outputs. `peek_data` is combinational from the state registers, so an UPDATE write is visible the cycle after.

## Structure
- Shared package `lif_pkg`: FSM state enum, `W`, default `THRESHOLD` and `LEAK_SHIFT` constants.
- Sub-module `lif_update` (combinational): inputs v, cur; outputs next_v, fire. It contains the leak/saturate/threshold arithmetic and is reusable by other LIF blocks.
- The scheduler owns the register arrays, the idx counter, the FSM, and the handshake.

## Test plan
All scenarios use N=4, W=8, THRESHOLD=200, LEAK_SHIFT=2.
- Reset mid-sweep (assert in UPDATE idx 2): all outputs 0 next cycle, `peek_data`=0 for every index, FSM IDLE, `start` accepted afterward.
- cur[0]=100, others 0, three sweeps, `spike_ready`=1: v0 = 100, then 175, then 232 → spike `spike_id`=0, v0=0. Sweeps 1–2 assert `done` 5 cycles after `start`; sweep 3 asserts it after 6.
- Saturation: cur[1]=150, sweep → v1=150. Set cur[1]=255, sweep → 150−37+255 = 368, saturates to 255 → spike id 1, v1=0.
- All cur=250, `spike_ready`=1: spikes ids 0,1,2,3 in order, `done` 9 cycles after `start`.
- Backpressure: a single spike on id 2 with `spike_ready` low for 5 cycles. `spike_valid`/`spike_id`=2 held stable, neuron 3 not updated until acceptance, `done` delayed by exactly 5 cycles.
- Concurrency: `start` pulsed while `busy` is ignored. `cur_we` to idx 1 during its UPDATE cycle: that sweep uses the old current and the next sweep uses the new one.
